// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : led_pkg                                                          |
// | Brief   : Shared sizing constants for the LED counter / PWM driver path.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package led_pkg;
    localparam int LED_COUNT_DEF = 8;
    localparam int PWM_BITS_DEF  = 8;
    localparam int PWM_MAX       = (1 << PWM_BITS_DEF) - 1;
endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pwm_timebase                                                     |
// | Brief   : Prescaler plus PWM step counter; flags step ticks and the last   |
// |           step of each PWM period.                                         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pwm_timebase #(
    parameter int PRESCALE = 195,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] o_pwm_count,
    output logic                o_tick,
    output logic                o_boundary
);
    // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     c_ps_last  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] c_pwm_last = '1;

    logic [PS_W-1:0]     prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0] pwm_count_q, pwm_count_d;
    logic                w_tick;

    assign w_tick = (prescaler_q == c_ps_last);

    always_comb begin
        prescaler_d = w_tick ? '0 : prescaler_q + 1'b1;
        pwm_count_d = w_tick ? pwm_count_q + 1'b1 : pwm_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            pwm_count_q <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            pwm_count_q <= pwm_count_d;
        end
    end

    assign o_pwm_count = pwm_count_q;
    assign o_tick      = w_tick;
    assign o_boundary  = w_tick && (pwm_count_q == c_pwm_last);
endmodule
`default_nettype wire

// File: rtl/led_pwm_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : led_pwm_driver                                                   |
// | Brief   : Holds the LED pattern and drives it through a global PWM dimmer; |
// |           pattern and brightness change only at PWM period boundaries.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PRESCALE  = 195,
    parameter int LED_COUNT = LED_COUNT_DEF,
    parameter int PWM_BITS  = PWM_BITS_DEF
) (
    input  logic                 ipClk,
    input  logic                 ipReset,
    input  logic [LED_COUNT-1:0] ipValue,
    input  logic                 ipValid,
    input  logic [PWM_BITS-1:0]  ipBrightness,
    output logic [LED_COUNT-1:0] opLED,
    output logic                 opPeriodStart
);
    localparam logic [PWM_BITS-1:0] c_pwm_full = '1;

    logic [PWM_BITS-1:0]  w_pwm_count;
    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_on;
    logic                 w_unused_tick;

    logic [LED_COUNT-1:0] pending_q, pending_d;
    logic [LED_COUNT-1:0] shadow_value_q, shadow_value_d;
    logic [PWM_BITS-1:0]  shadow_bright_q, shadow_bright_d;
    logic [LED_COUNT-1:0] led_q, led_d;
    logic                 period_start_q, period_start_d;

    pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk         (ipClk),
        .rst         (ipReset),
        .o_pwm_count (w_pwm_count),
        .o_tick      (w_tick),
        .o_boundary  (w_boundary)
    );

    // The raw step tick is exported by the timebase for other consumers only.
    assign w_unused_tick = w_tick;

    // Full brightness is forced on so there is no single dark step per period.
    assign w_on = (shadow_bright_q == c_pwm_full) || (w_pwm_count < shadow_bright_q);

    always_comb begin
        pending_d       = ipValid ? ipValue : pending_q;
        shadow_value_d  = shadow_value_q;
        shadow_bright_d = shadow_bright_q;
        if (w_boundary) begin
            shadow_value_d  = ipValid ? ipValue : pending_q;
            shadow_bright_d = ipBrightness;
        end
        led_d          = w_on ? shadow_value_q : '0;
        period_start_d = w_boundary;
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            pending_q       <= '0;
            shadow_value_q  <= '0;
            shadow_bright_q <= '0;
            led_q           <= '0;
            period_start_q  <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            shadow_value_q  <= shadow_value_d;
            shadow_bright_q <= shadow_bright_d;
            led_q           <= led_d;
            period_start_q  <= period_start_d;
        end
    end

    assign opLED         = led_q;
    assign opPeriodStart = period_start_q;
endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_led_pwm_driver                                                |
// | Brief   : Scoreboard bench for led_pwm_driver against a period-level model.|
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_led_pwm_driver;
    localparam int P = 2;
    localparam int L = 256 * P;

    typedef struct {
        logic [7:0] led;
        logic       ps;
    } exp_t;

    logic       ipClk = 1'b0;
    logic       ipReset = 1'b1;
    logic [7:0] ipValue = 8'h00;
    logic       ipValid = 1'b0;
    logic [7:0] ipBrightness = 8'h00;
    logic [7:0] opLED;
    logic       opPeriodStart;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: position within the period is derived from cycles since reset.
    bit         m_ok = 0;
    int         m_cnt = 0;
    logic [7:0] m_pend = 0, m_sv = 0, m_sb = 0;

    led_pwm_driver #(
        .PRESCALE  (P),
        .LED_COUNT (8),
        .PWM_BITS  (8)
    ) dut (
        .ipClk         (ipClk),
        .ipReset       (ipReset),
        .ipValue       (ipValue),
        .ipValid       (ipValid),
        .ipBrightness  (ipBrightness),
        .opLED         (opLED),
        .opPeriodStart (opPeriodStart)
    );

    always #10 ipClk = ~ipClk;

    task automatic model_edge();
        exp_t e;
        int   pos, step;
        if (ipReset) begin
            m_ok = 1; m_cnt = 0; m_pend = 0; m_sv = 0; m_sb = 0;
            e.led = 8'h00; e.ps = 1'b0;
        end else begin
            pos   = m_cnt % L;
            step  = pos / P;
            e.led = (m_sb == 8'd255 || step < int'(m_sb)) ? m_sv : 8'h00;
            e.ps  = (pos == L - 1);
            if (pos == L - 1) begin
                m_sv = ipValid ? ipValue : m_pend;
                m_sb = ipBrightness;
            end
            if (ipValid) m_pend = ipValue;
            m_cnt++;
        end
        if (m_ok) q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic v, input logic [7:0] val, input logic [7:0] br);
        ipReset = r; ipValid = v; ipValue = val; ipBrightness = br;
        @(posedge ipClk);
        #1;
        model_edge();
    endtask

    task automatic idle(input int n, input logic [7:0] br);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, $urandom, br);
    endtask

    // Monitor: the outputs are presented every cycle, so compare on every falling edge.
    always @(negedge ipClk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (opLED === e.led) n_pass++;
            else $display("FAIL opLED cnt=%0d actual=%h required=%h", m_cnt, opLED, e.led);
            n_chk++;
            if (opPeriodStart === e.ps) n_pass++;
            else $display("FAIL opPeriodStart cnt=%0d actual=%b required=%b", m_cnt, opPeriodStart, e.ps);
        end
    end

    initial begin
        logic [7:0] br;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 8'h00);

        // Capture A5 at brightness 128 in the first period, then watch three periods.
        idle(10, 8'd128);
        cyc(1'b0, 1'b1, 8'hA5, 8'd128);
        idle(3 * L, 8'd128);

        // Brightness 0, then full brightness with all LEDs lit across wraps.
        while ((m_cnt % L) != 100) idle(1, 8'd0);
        idle(L + 20, 8'd0);
        cyc(1'b0, 1'b1, 8'hFF, 8'd255);
        idle(3 * L, 8'd255);

        // Last-wins capture, with a valid landing on the boundary cycle itself.
        while ((m_cnt % L) != 200) idle(1, 8'd160);
        cyc(1'b0, 1'b1, 8'h0F, 8'd160);
        idle(50, 8'd160);
        cyc(1'b0, 1'b1, 8'hF0, 8'd160);
        while ((m_cnt % L) != L - 1) idle(1, 8'd160);
        cyc(1'b0, 1'b1, 8'h3C, 8'd160);
        idle(L + 10, 8'd160);

        // Reset mid-period while lit, then show A5 again and hit reset mid on-phase.
        cyc(1'b0, 1'b1, 8'hA5, 8'd128);
        while ((m_cnt % L) != L - 1) idle(1, 8'd128);
        idle(60, 8'd128);
        cyc(1'b1, 1'b0, 8'h00, 8'd128);
        idle(L + 20, 8'd128);

        // Randomized traffic with occasional resets and biased brightness values.
        for (int i = 0; i < 6000; i++) begin
            case ($urandom_range(0, 3))
                0:       br = 8'd0;
                1:       br = 8'd255;
                default: br = 8'($urandom);
            endcase
            cyc(($urandom_range(0, 2999) == 0), ($urandom_range(0, 99) == 0), 8'($urandom), br);
        end

        @(negedge ipClk);
        @(negedge ipClk);
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
